uart_rx_byte: RTL

//  Receives 8N1 asynchronous serial frames on usb_rx and presents each byte on
//  a valid/ready interface. It is the receive-side companion to the serial echo

---
 rtl/uart_rx_byte.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with a valid/ready byte output.
// Flags stop-bit framing errors and bytes dropped while the consumer stalls.
module uart_rx_byte #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       usb_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CPB   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_busy;

    assign w_rx_s    = r_sync2;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= usb_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM: mid-bit sampling, byte delivery, handshake and error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_FULL) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            // A byte accepted this same cycle frees the slot for the new one.
                            if (!r_rx_valid || rx_ready) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BRK;
                        end
                    end
                end
                S_BRK: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
